// File: rtl/tap_frame_pkg.sv
// ---------------------------------------------------------------------------
// tap_frame_pkg
// Shared constants and helpers for the JTAG user-DR frame decoder.
//   - STATUS_* : bit positions of the status word loaded on Capture-DR
//   - clog2_min1 : clog2 clamped to a minimum of 1 (channel field width)
//   - frame_width : total frame width for a payload/channel combination
//   - upd_res_e : outcome of the checks performed on Update-DR
// ---------------------------------------------------------------------------
package tap_frame_pkg;

  localparam int unsigned STATUS_LENGTH_BIT   = 0;
  localparam int unsigned STATUS_CHANNEL_BIT  = 1;
  localparam int unsigned STATUS_OVERFLOW_BIT = 2;
  localparam int unsigned STATUS_LEVEL_LSB    = 3;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned frame_width(input int unsigned data_width,
                                              input int unsigned channels);
    return data_width + clog2_min1(channels);
  endfunction

  typedef enum logic [1:0] {
    UpdPush,
    UpdErrLength,
    UpdErrChannel,
    UpdErrOverflow
  } upd_res_e;

endpackage

// File: rtl/tap_frame_decoder_fifo.sv
// ---------------------------------------------------------------------------
// tap_frame_fifo
// Synchronous FIFO with a registered head entry.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and data (ignored when full without pop)
//   i_pop          : read strobe (ignored when empty)
//   o_data         : head entry, registered
//   o_valid        : FIFO not empty, registered
//   o_full         : level == DEPTH
//   o_level        : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module tap_frame_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [LW-1:0]    o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;
  logic [LW-1:0] w_level_next;

  assign o_full       = (r_level == LW'(DEPTH));
  assign w_pop        = i_pop && (r_level != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push       = i_push && (!o_full || w_pop);
  assign w_rd_next    = r_rd_ptr + AW'(1);
  assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      r_level <= w_level_next;
      r_valid <= (w_level_next != '0);
      // The incoming word becomes the head when nothing else will remain
      // ahead of it; otherwise a pop advances to the next stored entry.
      if (w_push && ((r_level == '0) || ((r_level == LW'(1)) && w_pop))) begin
        r_head <= i_data;
      end else if (w_pop) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_level = r_level;

endmodule

// File: rtl/tap_frame_decoder.sv
// ---------------------------------------------------------------------------
// tap_frame_decoder
// Deserialises LSB-first user-DR shifts into {payload, channel} frames,
// checks length and channel on Update-DR and buffers good frames in a FIFO.
// Ports (all in the tck domain):
//   tck, rst_n           : clock, asynchronous active-low reset
//   tdi, tdo             : serial in, serial out (= shift_reg[0])
//   ir_is_user           : gates every TAP-side action
//   capture_dr/shift_dr/update_dr : TAP state strobes
//   m_data, m_channel, m_valid, m_ready : FIFO head with valid/ready
//   err_length/err_channel/err_overflow : one-cycle error pulses
// ---------------------------------------------------------------------------
module tap_frame_decoder
  import tap_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_BITS   = clog2_min1(CHANNELS)
) (
  input  logic                  tck,
  input  logic                  rst_n,
  input  logic                  tdi,
  input  logic                  ir_is_user,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  tdo,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CH_BITS-1:0]    m_channel,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_length,
  output logic                  err_channel,
  output logic                  err_overflow
);

  localparam int unsigned FRAME_WIDTH = frame_width(DATA_WIDTH, CHANNELS);
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W       = $clog2(FRAME_WIDTH + 2);
  localparam int unsigned STATUS_W    = STATUS_LEVEL_LSB + LVL_W;
  localparam int unsigned EXT_W       = (FRAME_WIDTH > STATUS_W) ? FRAME_WIDTH : STATUS_W;

  logic [FRAME_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_sticky_length;
  logic                   r_sticky_channel;
  logic                   r_sticky_overflow;
  logic                   r_err_length;
  logic                   r_err_channel;
  logic                   r_err_overflow;

  logic [FRAME_WIDTH-1:0] w_head;
  logic [LVL_W-1:0]       w_fifo_level;
  logic                   w_fifo_full;
  logic                   w_fifo_valid;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_update;
  upd_res_e               w_upd_res;
  logic [EXT_W-1:0]       w_status_ext;

  assign w_pop    = w_fifo_valid && m_ready;
  assign w_update = ir_is_user && update_dr;
  assign w_push   = w_update && (w_upd_res == UpdPush);

  always_comb begin
    if (r_bit_cnt != CNT_W'(FRAME_WIDTH)) begin
      w_upd_res = UpdErrLength;
    end else if (32'(r_shift[CH_BITS-1:0]) >= CHANNELS) begin
      w_upd_res = UpdErrChannel;
    end else if (w_fifo_full && !w_pop) begin
      w_upd_res = UpdErrOverflow;
    end else begin
      w_upd_res = UpdPush;
    end
  end

  // Status is built wide enough for the level field, then truncated to the
  // frame width for very narrow frames.
  always_comb begin
    w_status_ext                                 = '0;
    w_status_ext[STATUS_LENGTH_BIT]              = r_sticky_length;
    w_status_ext[STATUS_CHANNEL_BIT]             = r_sticky_channel;
    w_status_ext[STATUS_OVERFLOW_BIT]            = r_sticky_overflow;
    w_status_ext[STATUS_LEVEL_LSB +: LVL_W]      = w_fifo_level;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_shift           <= '0;
      r_bit_cnt         <= '0;
      r_sticky_length   <= 1'b0;
      r_sticky_channel  <= 1'b0;
      r_sticky_overflow <= 1'b0;
      r_err_length      <= 1'b0;
      r_err_channel     <= 1'b0;
      r_err_overflow    <= 1'b0;
    end else begin
      r_err_length   <= 1'b0;
      r_err_channel  <= 1'b0;
      r_err_overflow <= 1'b0;
      if (ir_is_user) begin
        if (capture_dr) begin
          r_shift           <= w_status_ext[FRAME_WIDTH-1:0];
          r_bit_cnt         <= '0;
          r_sticky_length   <= 1'b0;
          r_sticky_channel  <= 1'b0;
          r_sticky_overflow <= 1'b0;
        end else if (shift_dr) begin
          r_shift <= {tdi, r_shift[FRAME_WIDTH-1:1]};
          if (r_bit_cnt != CNT_W'(FRAME_WIDTH + 1)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        // Evaluated after the capture clear so a same-edge set wins.
        if (update_dr) begin
          unique case (w_upd_res)
            UpdErrLength: begin
              r_err_length    <= 1'b1;
              r_sticky_length <= 1'b1;
            end
            UpdErrChannel: begin
              r_err_channel    <= 1'b1;
              r_sticky_channel <= 1'b1;
            end
            UpdErrOverflow: begin
              r_err_overflow    <= 1'b1;
              r_sticky_overflow <= 1'b1;
            end
            UpdPush: ;
          endcase
        end
      end
    end
  end

  tap_frame_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (tck),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full),
    .o_level (w_fifo_level)
  );

  assign tdo          = r_shift[0];
  assign m_valid      = w_fifo_valid;
  assign m_channel    = w_head[CH_BITS-1:0];
  assign m_data       = w_head[FRAME_WIDTH-1:CH_BITS];
  assign err_length   = r_err_length;
  assign err_channel  = r_err_channel;
  assign err_overflow = r_err_overflow;

endmodule
